softmax_exp_sum: RTL

SOFTMAX_EXP_SUM -- requirements
Module: softmax_exp_sum

---
 rtl/softmax_exp_sum.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/softmax_exp_sum.sv
// softmax_exp_sum
// First stage of a fixed-point softmax. Signed Q4.4 logits are turned into
// 2^x approximations, buffered and summed over one vector; once the vector
// closes, the position of the leading one of the sum becomes a shared
// exponent. The buffered powers are then replayed, one beat per element,
// toward the divider together with that exponent.
module softmax_exp_sum #(
  parameter int MAX_LEN = 16
) (
  input  logic        aclk,
  input  logic        rst_n,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic [7:0]  in_tdata,
  input  logic        in_tlast,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [7:0]  out_exponent,
  output logic [23:0] out_power,
  output logic        out_tlast,
  output logic        busy
);

  // Buffer index width, and count width (count reaches MAX_LEN itself).
  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    ACCUM,
    CALC,
    EMIT
  } state_t;

  state_t state;
  state_t state_next;

  logic [23:0]   buffer [MAX_LEN];
  logic [27:0]   sum;
  logic [CW-1:0] count;
  logic [CW-1:0] len;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    exponent;

  logic          in_fire;
  logic          vec_end;
  logic          out_fire;
  logic          beat_last;
  logic [3:0]    shift;
  logic [23:0]   power;
  logic [4:0]    sum_msb;
  logic [7:0]    exponent_next;

  // Index of the most significant set bit; the sum is never zero when used.
  function automatic logic [4:0] msb_index(input logic [27:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int b = 0; b < 28; b++) begin
      if (v[b]) idx = 5'(b);
    end
    return idx;
  endfunction

  // Acceptance depends only on the state, so no loop forms through in_tready.
  assign in_fire  = in_tvalid && (state == ACCUM);
  assign vec_end  = in_fire && (in_tlast || (count == LAST_SLOT));
  assign out_fire = out_tvalid && out_tready;

  // Flipping the sign bit of the signed integer part i gives i+8 as an
  // unsigned 0..15 shift amount; {1, f} is the 16+f mantissa.
  assign shift = in_tdata[7:4] ^ 4'b1000;
  assign power = 24'({1'b1, in_tdata[3:0]}) << shift;

  assign sum_msb       = msb_index(sum);
  assign exponent_next = {3'b000, sum_msb} - 8'd16;

  assign beat_last = (CW'(rd_ptr) == (len - CW'(1)));

  // State register.
  always_ff @(posedge aclk) begin
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers sample pre-edge values, regardless of block ordering.
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and input-side handshake.
  always_comb begin
    // NOTE: defaults first, so no path leaves a signal unassigned and
    // synthesis never infers a latch.
    state_next = state;
    in_tready  = 1'b0;
    case (state)
      ACCUM: begin
        in_tready = 1'b1;
        if (vec_end) state_next = CALC;
      end
      CALC: begin
        state_next = EMIT;
      end
      EMIT: begin
        if (out_fire && beat_last) state_next = ACCUM;
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  // Accumulation, exponent capture and the emit-side pointer and valid.
  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      count      <= '0;
      sum        <= '0;
      rd_ptr     <= '0;
      len        <= '0;
      exponent   <= '0;
      out_tvalid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            sum   <= sum + 28'(power);
            count <= count + CW'(1);
          end
        end
        CALC: begin
          exponent <= exponent_next;
          len      <= count;
          rd_ptr   <= '0;
        end
        EMIT: begin
          // The first EMIT cycle only raises valid, which gives the
          // two-cycle latency from the closing input to the first beat.
          if (!out_tvalid) begin
            out_tvalid <= 1'b1;
          end else if (out_tready) begin
            if (beat_last) begin
              out_tvalid <= 1'b0;
              sum        <= '0;
              count      <= '0;
              rd_ptr     <= '0;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Power buffer written on each accepted logit.
  always_ff @(posedge aclk) begin
    // NOTE: the buffer has no reset; a slot is always written before it is
    // read, and outputs are gated so stale contents never appear.
    if (in_fire) begin
      buffer[count[PW-1:0]] <= power;
    end
  end

  // Output beat; the payload is forced to zero outside a valid beat.
  assign out_power    = out_tvalid ? buffer[rd_ptr] : '0;
  assign out_exponent = exponent;
  assign out_tlast    = out_tvalid && beat_last;
  assign busy         = (state != ACCUM) || (count != '0);

endmodule
